// File: rtl/branch_pc_unit.sv
// Next-PC stage of the single-cycle RV32I core.
// Resolves branch/jump outcome from the comparator flags, owns the
// architectural PC, traps misaligned redirects into a halt state and keeps
// saturating retired/taken branch counters.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch,
    input  logic             jal,
    input  logic             jalr,
    input  logic [2:0]       funct3,
    input  logic [31:0]      imm,
    input  logic [31:0]      rs1_data,
    input  logic             breq,
    input  logic             brlt,
    output logic             brUn,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             pc_sel,
    output logic             halted,
    output logic             misalign_err,
    output logic             ctrl_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic signed [31:0] imm_s;
    logic               cond;
    logic               illegal_f3;
    logic               multi;
    logic               redirect;
    logic [31:0]        target;
    logic               misaligned;

    logic [31:0]        pc_nxt;
    logic [CNT_W-1:0]   br_nxt;
    logic [CNT_W-1:0]   tk_nxt;
    logic               mis_nxt;
    logic               ctrl_nxt;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        return v;
    endfunction

    assign imm_s      = imm;
    assign brUn       = branch & funct3[1];
    assign pc_plus4   = pc + 32'd4;
    assign illegal_f3 = (funct3[2:1] == 2'b01);
    assign multi      = (branch & jal) | (branch & jalr) | (jal & jalr);
    assign halted     = (state == HALT);

    // Branch condition decode from funct3; reserved encodings never take.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = breq;
            3'b001:  cond = ~breq;
            3'b100:  cond = brlt;
            3'b101:  cond = ~brlt;
            3'b110:  cond = brlt;
            3'b111:  cond = ~brlt;
            default: cond = 1'b0;
        endcase
    end

    // Redirect target and decision; conflicting control selects are ignored.
    always_comb begin
        target     = jalr ? ((rs1_data + imm_s) & ~32'h1) : (pc + imm_s);
        redirect   = ~multi & (jal | jalr | (branch & cond));
        pc_sel     = (state == RUN) & redirect;
        misaligned = pc_sel & target[1];
    end

    // Next-state and next-value logic for the PC, counters and sticky flags.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        br_nxt    = br_cnt;
        tk_nxt    = taken_cnt;
        mis_nxt   = misalign_err;
        ctrl_nxt  = ctrl_err;
        if ((state == RUN) && !stall) begin
            ctrl_nxt = ctrl_err | (branch & illegal_f3) | multi;
            if (misaligned) begin
                // Faulting redirect: keep the PC pointing at the offender.
                state_nxt = HALT;
                mis_nxt   = 1'b1;
                br_nxt    = sat_inc(br_cnt, branch);
            end else begin
                pc_nxt = pc_sel ? target : pc_plus4;
                br_nxt = sat_inc(br_cnt, branch & ~multi);
                tk_nxt = sat_inc(taken_cnt, branch & cond & ~multi);
            end
        end
    end

    // FSM state register; HALT is left only through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Architectural PC, counters and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            br_cnt       <= '0;
            taken_cnt    <= '0;
            misalign_err <= 1'b0;
            ctrl_err     <= 1'b0;
        end else begin
            pc           <= pc_nxt;
            br_cnt       <= br_nxt;
            taken_cnt    <= tk_nxt;
            misalign_err <= mis_nxt;
            ctrl_err     <= ctrl_nxt;
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios followed by
// randomized control flow, compared against a behavioural reference model.
module tb_branch_pc_unit;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             branch;
    logic             jal;
    logic             jalr;
    logic [2:0]       funct3;
    logic [31:0]      imm;
    logic [31:0]      rs1_data;
    logic             breq;
    logic             brlt;
    logic             brUn;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             pc_sel;
    logic             halted;
    logic             misalign_err;
    logic             ctrl_err;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_mis;
    bit          m_ctrl;
    int          m_br;
    int          m_tk;

    branch_pc_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch       (branch),
        .jal          (jal),
        .jalr         (jalr),
        .funct3       (funct3),
        .imm          (imm),
        .rs1_data     (rs1_data),
        .breq         (breq),
        .brlt         (brlt),
        .brUn         (brUn),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .pc_sel       (pc_sel),
        .halted       (halted),
        .misalign_err (misalign_err),
        .ctrl_err     (ctrl_err),
        .br_cnt       (br_cnt),
        .taken_cnt    (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout pc=%h", pc);
        $fatal(1, "simulation time limit expired");
    end

    // ---------------- reference model ----------------
    function automatic bit f_multi();
        return (int'(branch) + int'(jal) + int'(jalr)) > 1;
    endfunction

    function automatic bit f_legal();
        return !((funct3 == 3'd2) || (funct3 == 3'd3));
    endfunction

    // Bit 2 selects the less-than flag, bit 0 inverts the sense.
    function automatic bit f_cond();
        if (!f_legal()) return 1'b0;
        return (funct3[2] ? brlt : breq) ^ funct3[0];
    endfunction

    function automatic bit f_take();
        return !m_halt && !f_multi() && (jal || jalr || (branch && f_cond()));
    endfunction

    function automatic logic [31:0] f_tgt();
        if (jalr) return (rs1_data + imm) & 32'hFFFF_FFFE;
        return m_pc + imm;
    endfunction

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_halt = 0; m_mis = 0; m_ctrl = 0; m_br = 0; m_tk = 0;
    endtask

    task automatic model_update();
        bit          take;
        bit          multi;
        logic [31:0] tgt;
        if (m_halt || stall) return;
        take  = f_take();
        multi = f_multi();
        tgt   = f_tgt();
        if ((branch && !f_legal()) || multi) m_ctrl = 1;
        if (take && tgt[1]) begin
            m_halt = 1;
            m_mis  = 1;
            if (branch) m_br = sat(m_br);
        end else begin
            m_pc = take ? tgt : m_pc + 32'd4;
            if (branch && !multi) m_br = sat(m_br);
            if (branch && f_cond() && !multi) m_tk = sat(m_tk);
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc",           pc,                  m_pc);
        chk("pc_plus4",     pc_plus4,            m_pc + 32'd4);
        chk("brUn",         32'(brUn),           32'(branch & funct3[1]));
        chk("pc_sel",       32'(pc_sel),         32'(f_take()));
        chk("halted",       32'(halted),         32'(m_halt));
        chk("misalign_err", 32'(misalign_err),   32'(m_mis));
        chk("ctrl_err",     32'(ctrl_err),       32'(m_ctrl));
        chk("br_cnt",       32'(br_cnt),         32'(m_br));
        chk("taken_cnt",    32'(taken_cnt),      32'(m_tk));
    endtask

    // Check outputs mid-cycle, then advance one edge; returns at edge+1.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic b, input logic j, input logic jr, input logic [2:0] f3,
                          input logic [31:0] im, input logic [31:0] r1,
                          input logic eq, input logic lt, input logic st);
        branch = b; jal = j; jalr = jr; funct3 = f3; imm = im;
        rs1_data = r1; breq = eq; brlt = lt; stall = st;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_pc", pc, 32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int halt_cycles;
        logic [31:0] r;

        rst_n = 1'b0;
        idle();
        model_reset();
        #2;
        check_all();
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three idle cycles from reset
        repeat (3) cycle();
        chk("idle_pc", pc, 32'd12);

        // Move to 0x100, then BEQ taken
        set_in(0, 0, 1, 3'd0, 32'h0, 32'h100, 0, 0, 0); cycle();
        set_in(1, 0, 0, 3'b000, 32'h40, 32'h0, 1, 0, 0); cycle();
        chk("beq_pc", pc, 32'h140);
        chk("beq_br", 32'(br_cnt), 32'd1);
        chk("beq_tk", 32'(taken_cnt), 32'd1);

        // BLTU taken (brUn=1 checked at the negedge)
        set_in(1, 0, 0, 3'b110, 32'h20, 32'h0, 0, 1, 0); cycle();
        chk("bltu_pc", pc, 32'h160);

        // BGE not taken
        set_in(1, 0, 0, 3'b101, 32'h80, 32'h0, 0, 1, 0); cycle();
        chk("bge_pc", pc, 32'h164);
        chk("bge_tk", 32'(taken_cnt), 32'd2);

        // JALR clears bit 0
        set_in(0, 0, 1, 3'd0, 32'h0, 32'h2001, 0, 0, 0); cycle();
        chk("jalr_pc", pc, 32'h2000);

        // Stall during a taken branch, then release
        set_in(1, 0, 0, 3'b000, 32'h10, 32'h0, 1, 0, 1);
        repeat (3) cycle();
        chk("stall_pc", pc, 32'h2000);
        stall = 1'b0; cycle();
        chk("unstall_pc", pc, 32'h2010);

        // Illegal funct3
        set_in(1, 0, 0, 3'b010, 32'h40, 32'h0, 1, 1, 0); cycle();
        chk("illegal_ctrl", 32'(ctrl_err), 32'd1);
        chk("illegal_pc", pc, 32'h2014);

        // Reset while stalled, then branch+jal conflict
        set_in(1, 0, 0, 3'b000, 32'h10, 32'h0, 1, 0, 1); cycle();
        do_reset();
        set_in(1, 1, 0, 3'b000, 32'h40, 32'h0, 1, 0, 0); cycle();
        chk("multi_ctrl", 32'(ctrl_err), 32'd1);
        chk("multi_pc", pc, 32'h4);

        // Counter saturation
        set_in(1, 0, 0, 3'b000, 32'h8, 32'h0, 1, 0, 0);
        repeat (20) cycle();
        chk("sat_br", 32'(br_cnt), 32'd15);
        chk("sat_tk", 32'(taken_cnt), 32'd15);

        // PC wrap at the top of the address space
        set_in(0, 0, 1, 3'd0, 32'h0, 32'hFFFF_FFFC, 0, 0, 0); cycle();
        chk("top_pc", pc, 32'hFFFF_FFFC);
        idle(); cycle();
        chk("wrap_pc", pc, 32'h0);

        // Misaligned JAL halts the core
        set_in(0, 0, 1, 3'd0, 32'h0, 32'h100, 0, 0, 0); cycle();
        set_in(0, 1, 0, 3'd0, 32'h6, 32'h0, 0, 0, 0); cycle();
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_halt", 32'(halted), 32'd1);
        set_in(1, 0, 0, 3'b000, 32'h40, 32'h0, 1, 0, 0); cycle();
        set_in(0, 0, 1, 3'd0, 32'h0, 32'h400, 0, 0, 0); cycle();
        chk("halt_pc", pc, 32'h100);
        do_reset();
        chk("rst_halt", 32'(halted), 32'd0);

        // Randomized control flow
        halt_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            int kind;
            kind = $urandom_range(0, 7);
            branch = (kind >= 2 && kind <= 4);
            jal    = (kind == 5);
            jalr   = (kind == 6);
            if (kind == 7) begin
                branch = $urandom_range(0, 1);
                jal    = $urandom_range(0, 1);
                jalr   = $urandom_range(0, 1);
            end
            funct3 = 3'($urandom_range(0, 7));
            r      = 32'($urandom_range(0, 255));
            imm    = (r << 2) - 32'd512;
            if ($urandom_range(0, 19) == 0) imm = imm | 32'h2;
            rs1_data = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
            if ($urandom_range(0, 9) != 0) rs1_data = rs1_data & ~32'h2;
            breq  = $urandom_range(0, 1);
            brlt  = $urandom_range(0, 1);
            stall = ($urandom_range(0, 7) == 0);
            cycle();
            if (m_halt) begin
                halt_cycles++;
                if (halt_cycles > 2) begin
                    do_reset();
                    halt_cycles = 0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
